// File: rtl/gcn_mem_server.sv
// Memory responder for the GCN core: streaming fill of weights, features and COO edges
// after reset, then 1-cycle-latency row reads plus combinational COO lookup.
module gcn_mem_server #(
  parameter int FEATURE_ROWS    = 6,
  parameter int FEATURE_COLS    = 96,
  parameter int WEIGHT_ROWS     = 96,
  parameter int WEIGHT_COLS     = 3,
  parameter int FEATURE_WIDTH   = 5,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int FEATURE_BASE    = 512,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      load_valid,
  input  logic [FEATURE_WIDTH-1:0]                  load_data,
  output logic                                      load_ready,
  output logic                                      mem_ready,
  input  logic                                      enable_read,
  input  logic [ADDRESS_WIDTH-1:0]                  read_address,
  output logic [WEIGHT_ROWS-1:0][FEATURE_WIDTH-1:0] data_out,
  output logic                                      data_valid,
  output logic                                      addr_error,
  input  logic [COO_BW-1:0]                         coo_address,
  output logic [2*COO_BW-1:0]                       coo_out
);
  localparam int ELEM_W = $clog2(WEIGHT_ROWS);
  localparam int ROW_W  = $clog2(FEATURE_ROWS);
  localparam int WR_W   = $clog2(WEIGHT_COLS);

  typedef enum logic [1:0] {LOAD_W, LOAD_F, LOAD_C, SERVE} state_t;
  typedef logic [WEIGHT_ROWS-1:0][FEATURE_WIDTH-1:0] row_t;

  row_t              w_mem [WEIGHT_COLS];
  row_t              f_mem [FEATURE_ROWS];
  logic [COO_BW-1:0] src_mem [COO_NUM_OF_COLS];
  logic [COO_BW-1:0] dst_mem [COO_NUM_OF_COLS];

  state_t            state_q, state_d;
  logic [ELEM_W-1:0] elem_q, elem_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              load_ready_q, load_ready_d;
  logic              mem_ready_q, mem_ready_d;
  row_t              data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              addr_error_q, addr_error_d;

  logic              accept, elem_last, row_last;
  logic              rd_feat, rd_ok;
  logic [ADDRESS_WIDTH-1:0] rd_fidx;
  row_t              rd_row;

  assign accept = load_valid && load_ready_q;

  // Row decode: addresses at/above the feature base select feature rows.
  always_comb begin
    rd_feat = read_address >= ADDRESS_WIDTH'(FEATURE_BASE);
    rd_fidx = read_address - ADDRESS_WIDTH'(FEATURE_BASE);
    rd_ok   = rd_feat ? (rd_fidx < ADDRESS_WIDTH'(FEATURE_ROWS))
                      : (read_address < ADDRESS_WIDTH'(WEIGHT_COLS));
    rd_row  = rd_feat ? f_mem[rd_fidx[ROW_W-1:0]] : w_mem[read_address[WR_W-1:0]];
  end

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    row_d        = row_q;
    elem_last    = 1'b0;
    row_last     = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    addr_error_d = 1'b0;
    case (state_q)
      LOAD_W: begin
        elem_last = elem_q == ELEM_W'(WEIGHT_ROWS-1);
        row_last  = row_q  == ROW_W'(WEIGHT_COLS-1);
      end
      LOAD_F: begin
        elem_last = elem_q == ELEM_W'(FEATURE_COLS-1);
        row_last  = row_q  == ROW_W'(FEATURE_ROWS-1);
      end
      LOAD_C: begin
        // row 0 carries source nodes, row 1 destination nodes
        elem_last = elem_q == ELEM_W'(COO_NUM_OF_COLS-1);
        row_last  = row_q  == ROW_W'(1);
      end
      default: ;
    endcase
    if (accept) begin
      if (elem_last) begin
        elem_d = '0;
        if (row_last) begin
          row_d   = '0;
          state_d = (state_q == LOAD_W) ? LOAD_F :
                    (state_q == LOAD_F) ? LOAD_C : SERVE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        elem_d = elem_q + 1'b1;
      end
    end
    load_ready_d = state_d != SERVE;
    mem_ready_d  = mem_ready_q || (state_d == SERVE);
    if (state_q == SERVE && enable_read) begin
      if (rd_ok) begin
        data_out_d   = rd_row;
        data_valid_d = 1'b1;
      end else begin
        addr_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD_W;
      elem_q       <= '0;
      row_q        <= '0;
      load_ready_q <= 1'b1;
      mem_ready_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      row_q        <= row_d;
      load_ready_q <= load_ready_d;
      mem_ready_q  <= mem_ready_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      addr_error_q <= addr_error_d;
    end
  end

  // Storage has no reset: a reload overwrites every entry anyway.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (state_q)
        LOAD_W: w_mem[row_q[WR_W-1:0]][elem_q] <= load_data;
        LOAD_F: f_mem[row_q][elem_q] <= load_data;
        LOAD_C: begin
          if (!row_q[0]) src_mem[elem_q[COO_BW-1:0]] <= load_data[COO_BW-1:0];
          else           dst_mem[elem_q[COO_BW-1:0]] <= load_data[COO_BW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign coo_out = (state_q == SERVE && coo_address < COO_BW'(COO_NUM_OF_COLS))
                 ? {src_mem[coo_address], dst_mem[coo_address]} : '0;

  assign load_ready = load_ready_q;
  assign mem_ready  = mem_ready_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign addr_error = addr_error_q;
endmodule

// File: tb/tb_gcn_mem_server.sv
// Scoreboard bench for gcn_mem_server: directed load/read/COO vectors, in-order response queue.
module tb_gcn_mem_server;
  localparam int EW = 5, NE = 96, AW = 13, CB = 3, NBEATS = 876;
  typedef logic [NE-1:0][EW-1:0] row_t;
  typedef struct packed { logic err; row_t row; } exp_t;

  logic clk = 1'b0, reset = 1'b1;
  logic load_valid = 1'b0, load_ready, mem_ready;
  logic [EW-1:0] load_data = '0;
  logic enable_read = 1'b0;
  logic [AW-1:0] read_address = '0;
  row_t data_out;
  logic data_valid, addr_error;
  logic [CB-1:0] coo_address = '0;
  logic [2*CB-1:0] coo_out;

  gcn_mem_server dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .mem_ready(mem_ready), .enable_read(enable_read),
    .read_address(read_address), .data_out(data_out), .data_valid(data_valid),
    .addr_error(addr_error), .coo_address(coo_address), .coo_out(coo_out));

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  row_t last_row = '0;
  int n_chk = 0, n_pass = 0, spur_cnt = 0, cyc;

  task automatic chk(input string name, input logic [NE*EW-1:0] act, input logic [NE*EW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] beat_val(input int k);
    int j;
    if (k < 288) return EW'(((k / 96) + (k % 96)) % 32);
    if (k < 864) begin j = k - 288; return EW'((3 * (j / 96) + (j % 96)) % 32); end
    j = k - 864;
    return (j < 6) ? EW'(j) : EW'((j - 6 + 1) % 6);
  endfunction

  function automatic row_t exp_row(input int a);
    row_t r;
    for (int i = 0; i < NE; i++)
      r[i] = (a >= 512) ? EW'((3 * (a - 512) + i) % 32) : EW'((a + i) % 32);
    return r;
  endfunction

  // Monitor: every response the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && (data_valid || addr_error)) begin
      if (exp_q.size() == 0) begin
        spur_cnt++;
        $display("FAIL unexpected_response: dv=%0b ae=%0b with empty queue", data_valid, addr_error);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_kind", {data_valid, addr_error}, mon_e.err ? 2'b01 : 2'b10);
        chk("resp_data", data_out, mon_e.row);
      end
    end
  end

  task automatic rd(input int a);
    bit ok;
    ok = (a >= 512) ? (a - 512 < 6) : (a < 3);
    enable_read = 1'b1;
    read_address = AW'(a);
    if (ok) last_row = exp_row(a);
    exp_q.push_back('{err: !ok, row: last_row});
    @(posedge clk); #1;
    enable_read = 1'b0;
  endtask

  task automatic load_all(input bit gap, output int cycles);
    cycles = 0;
    for (int k = 0; k < NBEATS; k++) begin
      if (gap) begin
        load_valid = 1'b0;
        @(posedge clk); #1; cycles++;
      end
      load_valid = 1'b1;
      load_data = beat_val(k);
      if (k == NBEATS - 1) begin
        enable_read = 1'b0;
        chk("mem_ready_before_last_beat", mem_ready, 0);
      end
      @(posedge clk); #1; cycles++;
    end
    load_valid = 1'b0;
    chk("mem_ready_after_load", mem_ready, 1);
    chk("load_ready_after_load", load_ready, 0);
  endtask

  initial begin
    coo_address = 3'd4;
    #2 reset = 1'b0;
    #1;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_addr_error", addr_error, 0);
    chk("rst_coo_out", coo_out, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Abort a load after 100 beats; the full sequence must restart from zero.
    for (int k = 0; k < 100; k++) begin
      load_valid = 1'b1; load_data = beat_val(k);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    reset = 1'b0; #1;
    chk("midload_rst_load_ready", load_ready, 1);
    chk("midload_rst_mem_ready", mem_ready, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Reads issued during load must be ignored.
    enable_read = 1'b1; read_address = AW'(2);
    load_all(1'b0, cyc);
    chk("load_cycles", cyc, NBEATS);
    chk("no_resp_during_load", spur_cnt, 0);

    rd(2); rd(517);
    rd(0); rd(512); rd(1);
    @(posedge clk); #1;
    rd(3); rd(518); rd(8191);
    repeat (3) @(posedge clk); #1;
    chk("load_ready_serve", load_ready, 0);

    coo_address = 3'd4; #1 chk("coo_4", coo_out, 6'b100_101);
    coo_address = 3'd0; #1 chk("coo_0", coo_out, 6'b000_001);
    coo_address = 3'd5; #1 chk("coo_5", coo_out, 6'b101_000);
    coo_address = 3'd6; #1 chk("coo_6", coo_out, 0);
    coo_address = 3'd7; #1 chk("coo_7", coo_out, 0);
    chk("queue_drained_1", exp_q.size(), 0);

    // Reload with load_valid low every other cycle.
    coo_address = 3'd4;
    @(posedge clk); #1;
    reset = 1'b0; last_row = '0; #1;
    chk("rst2_coo_out", coo_out, 0);
    chk("rst2_mem_ready", mem_ready, 0);
    chk("rst2_data_out", data_out, 0);
    @(posedge clk); #1 reset = 1'b1;
    load_all(1'b1, cyc);
    chk("gap_load_cycles", cyc, 2 * NBEATS);
    rd(517); rd(1); rd(6); rd(513);
    repeat (3) @(posedge clk); #1;
    chk("queue_drained_2", exp_q.size(), 0);
    chk("no_spurious_total", spur_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gcn_mem_server.md
# gcn_mem_server

Synthesizable memory responder for the GCN core's read interface. It stores the weight matrix, feature matrix and COO adjacency list. It answers the core's row reads (`enable_read`/`read_address` → `data_in`) and COO lookups (`coo_address` → `coo_in`). Contents are filled once after reset through a streaming load port, after which the block serves reads only; it replaces the behavioural bench memory.

## Interface
- FEATURE_ROWS, 6, feature matrix rows (nodes)
- FEATURE_COLS, 96, feature row length; equals WEIGHT_ROWS
- WEIGHT_ROWS, 96, elements per returned row
- WEIGHT_COLS, 3, weight rows stored (one per output class)
- FEATURE_WIDTH, 5, element width; WEIGHT_WIDTH equal
- ADDRESS_WIDTH, 13, read address width
- FEATURE_BASE, 512, first feature-row address
- COO_NUM_OF_COLS, 6, edges stored
- COO_BW, $clog2(COO_NUM_OF_COLS), node index width; must be ≤ FEATURE_WIDTH
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears state and outputs immediately
- load_valid  in  1  load beat present
- load_data  in  FEATURE_WIDTH  load element
- load_ready  out  1  block accepts load beats
- mem_ready  out  1  load complete, reads served
- enable_read  in  1  row read request this cycle
- read_address  in  ADDRESS_WIDTH  row address
- data_out  out  WEIGHT_ROWS×FEATURE_WIDTH  returned row, element 0 first
- data_valid  out  1  data_out updated this cycle
- addr_error  out  1  one-cycle pulse, rejected read
- coo_address  in  COO_BW  edge index
- coo_out  out  2×COO_BW  {source node, destination node}

## Operation
- FSM states: LOAD_W → LOAD_F → LOAD_C → SERVE. Reset enters LOAD_W.
- A beat is accepted when load_valid && load_ready. load_ready = 1 in the LOAD_* states and 0 in SERVE.
- LOAD_W accepts WEIGHT_COLS×WEIGHT_ROWS beats (288), row-major: weight row 0 elements 0..95, then row 1, and so on.
- LOAD_F accepts FEATURE_ROWS×FEATURE_COLS beats (576), row-major.
- LOAD_C accepts 2×COO_NUM_OF_COLS beats (12). The first 6 beats are source nodes for edges 0..5; the next 6 are destination nodes. Only load_data[COO_BW-1:0] is stored.
- An element counter and a row counter advance per accepted beat. The transition to the next state happens on the last accepted beat of the current state. Gaps in load_valid simply stall.
- Row read decode:
  - read_address ≥ FEATURE_BASE → feature row (read_address − FEATURE_BASE).
  - Otherwise → weight row read_address.
  - Valid only if the row index < FEATURE_ROWS (feature) or < WEIGHT_COLS (weight).
- Out-of-range read in SERVE: data_out unchanged, data_valid = 0, addr_error = 1 for one cycle.
- enable_read outside SERVE: ignored entirely. No data_valid, no addr_error.
- data_out holds its last value whenever no valid read is served.
- coo_out is combinational: {src[coo_address], dst[coo_address]}.
  - If coo_address ≥ COO_NUM_OF_COLS, or the state is not SERVE, coo_out = 0.
- Reset mid-load discards partial contents. Counters return to 0 and the full load sequence must be repeated. Storage arrays themselves are not cleared.

## Timing
- Reset values: load_ready = 1, mem_ready = 0, data_out = 0, data_valid = 0, addr_error = 0. coo_out = 0 because the state is not SERVE.
- mem_ready rises in the cycle after the 12th COO beat is accepted, and stays high until reset.
- Read latency is 1 cycle. enable_read and read_address sampled at edge N produce data_out/data_valid (or addr_error) valid after edge N.
- Back-to-back reads are allowed, one per cycle, full throughput.
- data_valid and addr_error are single-cycle, registered, never both high.
- Total load time is 876 accepted beats; with load_valid held high this is 876 cycles.

## Test plan
- Reset then full load:
  - Weight row r element i = (r+i)%32; feature row n element i = (3n+i)%32; COO src = {0,1,2,3,4,5}, dst = {1,2,3,4,5,0}.
  - Required: mem_ready = 1 exactly 1 cycle after the 876th beat, and load_ready = 0 from then on.
- Read address 2: the next cycle, data_valid = 1 and data_out[i] = (2+i)%32.
- Read address 517: the next cycle, data_out[0] = 15 and data_out[1] = 16.
- Back-to-back reads at 0, 512, 1: data_valid high for 3 consecutive cycles with the matching rows.
- Range checks:
  - Read at 3: addr_error pulses for 1 cycle, data_valid = 0, data_out keeps the previous row.
  - Read at 518: same response as address 3.
  - coo_address 4 → coo_out = {4,5}; coo_address 7 → coo_out = 0.
- Stall and reset handling:
  - Deassert load_valid every other cycle: 1752 cycles to mem_ready.
  - Assert reset after 100 beats: load_ready = 1, the count restarts, and a subsequent full load reads back correctly.
  - enable_read during load produces no data_valid.
